adder_tree_accum: RTL and testbench

Parametrised, fully pipelined signed adder tree with a multi-beat accumulator. Each valid beat reduces NUM_IN operands to one sum through a registered binary tree. Consecutive beat sums are accumulated until a beat flagged `in_last` arrives, and the total is then emitted as one `out_valid` pulse. The block sits after the ternary multiply array and generalises the fixed 25-input kernel tree and the 4-input channel adder into one block. That block covers per-kernel reduction and reduction across input channels (Tn beats).

---
 rtl/adder_tree_accum.sv | 215 +++++++++++++++++++++
 tb/tb_adder_tree_accum.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_accum.sv
// adder_tree_accum
//   Fully pipelined signed adder tree followed by a multi-beat accumulator.
//   Each valid beat of NUM_IN operands is reduced to one sum through
//   D = clog2(NUM_IN) register stages. Beat sums are accumulated until a beat
//   flagged in_last leaves the tree. The total is then emitted as a
//   single-cycle out_valid pulse.
//
//   Optional feature macro: ADDER_TREE_ACCUM_SAT_EN
//     defined   : out_data saturates to the signed OUT_WIDTH range and the
//                 extra port out_sat flags a clamped result.
//     undefined : out_data is the low OUT_WIDTH bits of the total (wraps).
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   beat qualifier
//   in_last    final beat of the current accumulation (only when in_valid)
//   in_data    NUM_IN signed operands, operand k at [(k+1)*IN_WIDTH-1 : k*IN_WIDTH]
//   out_valid  single-cycle result strobe
//   out_data   accumulated result, signed, held until the next emit
//   out_beats  number of beats contained in out_data, held until the next emit
//   out_sat    (SAT_EN builds only) result was clamped
//   busy       a beat is in the tree or a partial accumulation is held
//
// Handshake: no backpressure. A beat is taken on every rising clk edge where
// in_valid=1; out_valid is a one-cycle strobe with no ready.
module adder_tree_accum #(
    parameter int NUM_IN    = 25,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [NUM_IN*IN_WIDTH-1:0]    in_data,
    output logic                          out_valid,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [CNT_WIDTH-1:0]          out_beats,
`ifdef ADDER_TREE_ACCUM_SAT_EN
    output logic                          out_sat,
`endif
    output logic                          busy
);

    localparam int D  = $clog2(NUM_IN);
    localparam int NP = 1 << D;
    localparam int TW = IN_WIDTH + D;

    // ------------------------------------------------------------------
    // Adder tree. Level 0 is the zero-padded operand vector; level l is a
    // register stage of NP>>l sums, each IN_WIDTH+l bits wide. Each add
    // sign-extends both inputs by one bit, so no level can overflow.
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int N = NP >> l;
        localparam int W = IN_WIDTH + l;

        logic signed [W-1:0] sum [N];

        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < N; k++) begin : g_op
                if (k < NUM_IN) begin : g_real
                    assign sum[k] = in_data[k*IN_WIDTH +: IN_WIDTH];
                end else begin : g_pad
                    assign sum[k] = '0;
                end
            end
        end else begin : g_node
            // Data registers carry no reset: stages with valid=0 are don't-care.
            always_ff @(posedge clk) begin
                for (int i = 0; i < N; i++) begin
                    sum[i] <= W'(g_lvl[l-1].sum[2*i]) + W'(g_lvl[l-1].sum[2*i+1]);
                end
            end
        end
    end

    logic signed [TW-1:0]        tree_sum;
    logic signed [ACC_WIDTH-1:0] sum_ext;

    assign tree_sum = g_lvl[D].sum[0];
    assign sum_ext  = ACC_WIDTH'(tree_sum);   // signed cast sign-extends

    // Valid/last shadow pipeline, one entry per tree level.
    logic [D-1:0] vld_q;
    logic [D-1:0] lst_q;
    logic         tree_valid;
    logic         tree_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            lst_q[0] <= in_valid & in_last;   // last without valid is dropped here
            for (int i = 1; i < D; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    assign tree_valid = vld_q[D-1];
    assign tree_last  = lst_q[D-1];

    // ------------------------------------------------------------------
    // Accumulator FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        S_FIRST = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        emit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FIRST;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        if (tree_valid) begin
            case (state_q)
                S_FIRST: begin
                    acc_d = sum_ext;
                    cnt_d = CNT_WIDTH'(1);
                end
                S_ACCUM: begin
                    acc_d = acc_q + sum_ext;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                default: begin
                    acc_d = sum_ext;
                    cnt_d = CNT_WIDTH'(1);
                end
            endcase
            if (tree_last) begin
                emit    = 1'b1;
                state_d = S_FIRST;
            end else begin
                state_d = S_ACCUM;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result reduction to OUT_WIDTH, taken from the updated total so the
    // strobe lands in the cycle after the last beat leaves the tree.
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] res_data;

`ifdef ADDER_TREE_ACCUM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic res_sat;

    always_comb begin
        res_data = acc_d[OUT_WIDTH-1:0];
        res_sat  = 1'b0;
        if (acc_d > SAT_MAX) begin
            res_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            res_sat  = 1'b1;
        end else if (acc_d < SAT_MIN) begin
            res_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            res_sat  = 1'b1;
        end
    end
`else
    assign res_data = acc_d[OUT_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
`ifdef ADDER_TREE_ACCUM_SAT_EN
            out_sat   <= 1'b0;
`endif
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_data  <= res_data;
                out_beats <= cnt_d;
`ifdef ADDER_TREE_ACCUM_SAT_EN
                out_sat   <= res_sat;
`endif
            end
        end
    end

    assign busy = (|vld_q) | (state_q == S_ACCUM);

endmodule

// File: tb/tb_adder_tree_accum.sv
// tb_adder_tree_accum
//   Directed bench for adder_tree_accum with default parameters
//   (NUM_IN=25, so tree depth 5 and last-beat-to-strobe latency 6).
//   A table of {operand pattern, beat count, expected total, expected beats}
//   records is driven one accumulation at a time; hand-written sequences
//   cover back-to-back accumulations, mid-operation reset and randomly
//   gapped beats with stray in_last flags.
module tb_adder_tree_accum;

    localparam int NUM_IN    = 25;
    localparam int IN_WIDTH  = 8;
    localparam int ACC_WIDTH = 24;
    localparam int OUT_WIDTH = 16;
    localparam int CNT_WIDTH = 16;
    localparam int LAT       = 6;
    localparam int EW        = OUT_WIDTH + CNT_WIDTH;

`ifdef ADDER_TREE_ACCUM_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_last;
    logic [NUM_IN*IN_WIDTH-1:0] in_data;
    logic                       out_valid;
    logic [OUT_WIDTH-1:0]       out_data;
    logic [CNT_WIDTH-1:0]       out_beats;
    logic                       busy;
`ifdef ADDER_TREE_ACCUM_SAT_EN
    logic                       out_sat;
`endif

    always #5 clk = ~clk;

    adder_tree_accum #(
        .NUM_IN   (NUM_IN),
        .IN_WIDTH (IN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_beats(out_beats),
`ifdef ADDER_TREE_ACCUM_SAT_EN
        .out_sat  (out_sat),
`endif
        .busy     (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic          exp_sat_q[$];

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [OUT_WIDTH-1:0] d, input int beats, input logic sat);
        // Called just after the last beat's accepting edge; strobe is LAT-1 edges later.
        exp_q.push_back({d, CNT_WIDTH'(beats)});
        exp_cyc_q.push_back(cyc + LAT - 1);
        exp_sat_q.push_back(sat);
    endtask

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got out_data %0d beats %0d, expected no strobe",
                         $signed(out_data), out_beats);
            end else begin
                logic [EW-1:0] e;
                int            c;
                logic          s;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                s = exp_sat_q.pop_front();
                check("out_data", $signed(out_data), $signed(e[EW-1:CNT_WIDTH]));
                check("out_beats", out_beats, e[CNT_WIDTH-1:0]);
                check("strobe_cycle", cyc, c);
`ifdef ADDER_TREE_ACCUM_SAT_EN
                check("out_sat", out_sat, s);
`else
                if (s !== 1'b0) $display("note: saturation expected in a wrap build");
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [NUM_IN*IN_WIDTH-1:0] make_data(input int mode, input int a,
                                                             input int b);
        logic [NUM_IN*IN_WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            case (mode)
                0:       d[k*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(a);
                1:       d[k*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'((k % 2 == 0) ? a : b);
                default: d[k*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(k);
            endcase
        end
        return d;
    endfunction

    function automatic int sum_ops(input logic [NUM_IN*IN_WIDTH-1:0] d);
        int s;
        logic signed [IN_WIDTH-1:0] op;
        s = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            op = d[k*IN_WIDTH +: IN_WIDTH];
            s += int'(op);
        end
        return s;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] model_out(input int total);
        if (SAT_ON && total > 32767) return 16'h7fff;
        if (SAT_ON && total < -32768) return 16'h8000;
        return OUT_WIDTH'(total);
    endfunction

    function automatic logic model_sat(input int total);
        return SAT_ON && (total > 32767 || total < -32768);
    endfunction

    task automatic drive(input logic v, input logic l, input logic [NUM_IN*IN_WIDTH-1:0] d);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for every outstanding expectation to be consumed.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_missing_results"}, exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        exp_sat_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        int    mode;      // 0: all a, 1: even k = a / odd k = b, 2: operand k = k
        int    a;
        int    b;
        int    beats;
        int    exp_data;
        int    exp_beats;
        bit    exp_sat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [NUM_IN*IN_WIDTH-1:0] d;
        int total;
        int nv;
        logic v;

        vecs[0] = '{"ones_1beat",   0,    1,    0,  1,    25,  1, 1'b0};
        vecs[1] = '{"alt_4beat",    1,  127, -128,  4,   460,  4, 1'b0};
        vecs[2] = '{"index_1beat",  2,    0,    0,  1,   300,  1, 1'b0};
        vecs[3] = '{"max_11beat",   0,  127,    0, 11, SAT_ON ?  32767 : -30611, 11, SAT_ON};
        vecs[4] = '{"min_11beat",   0, -128,    0, 11, SAT_ON ? -32768 :  30336, 11, SAT_ON};
        vecs[5] = '{"neg1_3beat",   0,   -1,    0,  3,   -75,  3, 1'b0};
        vecs[6] = '{"zero_1beat",   0,    0,    0,  1,     0,  1, 1'b0};

        // Reset values
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        idle(3);
        rst = 1'b0;
        idle(1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", $signed(out_data), 0);
        check("reset_out_beats", out_beats, 0);
        check("reset_busy", busy, 0);

        // Table-driven single accumulations
        for (int i = 0; i < 7; i++) begin
            d = make_data(vecs[i].mode, vecs[i].a, vecs[i].b);
            for (int b = 0; b < vecs[i].beats; b++) begin
                drive(1'b1, b == vecs[i].beats - 1, d);
                if (b == 0) check({vecs[i].name, "_busy_after_first"}, busy, 1);
            end
            push_exp(OUT_WIDTH'(vecs[i].exp_data), vecs[i].exp_beats, vecs[i].exp_sat);
            drain(vecs[i].name);
            idle(1);
            check({vecs[i].name, "_out_valid_single"}, out_valid, 0);
            check({vecs[i].name, "_out_data_hold"}, $signed(out_data),
                  $signed(OUT_WIDTH'(vecs[i].exp_data)));
            check({vecs[i].name, "_busy_idle"}, busy, 0);
            idle(2);
        end

        // Back-to-back: 2 beats then 3 beats of operand k = k (300 per beat),
        // no gap; strobes land 3 cycles apart.
        d = make_data(2, 0, 0);
        drive(1'b1, 1'b0, d);
        drive(1'b1, 1'b1, d);
        push_exp(16'd600, 2, 1'b0);
        drive(1'b1, 1'b0, d);
        drive(1'b1, 1'b0, d);
        drive(1'b1, 1'b1, d);
        push_exp(16'd900, 3, 1'b0);
        drain("back_to_back");
        idle(1);
        check("back_to_back_busy_idle", busy, 0);
        idle(2);

        // Reset after 2 of 4 beats; only the fresh one-beat result may appear.
        d = make_data(0, 127, 0);
        drive(1'b1, 1'b0, d);
        drive(1'b1, 1'b0, d);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midreset_busy_cleared", busy, 0);
        drive(1'b1, 1'b1, make_data(0, -1, 0));
        push_exp(16'hffe7, 1, 1'b0);   // -25
        drain("midreset");
        idle(8);
        check("midreset_busy_after", busy, 0);
        check("midreset_out_data_hold", $signed(out_data), -25);

        // Random valid gaps; in_last=1 on every invalid cycle must be ignored.
        total = 0;
        nv    = 0;
        for (int i = 0; i < 20; i++) begin
            v = 1'($urandom_range(0, 1));
            if (i == 19) v = 1'b1;
            d = '0;
            for (int k = 0; k < NUM_IN; k++) d[k*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom_range(0, 255));
            if (v) begin
                total += sum_ops(d);
                nv++;
                drive(1'b1, i == 19, d);
            end else begin
                drive(1'b0, 1'b1, d);
            end
        end
        push_exp(model_out(total), nv, model_sat(total));
        drain("random_gaps");
        idle(1);
        check("random_gaps_busy_idle", busy, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
